// File: rtl/csr_apb_ctrl_multi.sv
// rtl/csr_apb_ctrl_multi.sv - APB slave control FSM for the ALU CS register bank and FIFOs
// Optional macro CSR_ERR_CNT_EN adds a clear-on-read saturating error counter at NUM_DATA+3.
module csr_apb_ctrl_multi #(
  parameter int NUM_DATA       = 2,
  parameter int OPERATION_SIZE = 2,
  parameter logic [(1<<OPERATION_SIZE)-1:0] OP_VALID_MASK = 4'b0110,
  parameter int FIFO_OUT_WIDTH = 25,
  parameter int APB_BUS_SIZE   = 32,
  parameter int RD_WAIT        = 1,
`ifdef CSR_ERR_CNT_EN
  parameter int REG_NUMBER     = NUM_DATA + 4,
`else
  parameter int REG_NUMBER     = NUM_DATA + 3,
`endif
  parameter int ADDR_W         = $clog2(REG_NUMBER)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ADDR_W-1:0]         paddr,
  input  logic                      psel,
  input  logic                      penable,
  input  logic                      pwrite,
  input  logic [OPERATION_SIZE-1:0] ctrl_op,
  input  logic                      start_bit,
  input  logic [FIFO_OUT_WIDTH-1:0] final_result,
  input  logic [FIFO_OUT_WIDTH-1:0] fifo_out_status,
  input  logic                      full_in,
  input  logic                      empty_out,
  output logic [APB_BUS_SIZE-1:0]   prdata,
  output logic                      pready,
  output logic                      pslverr,
  output logic                      en_ctrl,
  output logic [NUM_DATA-1:0]       en_data,
  output logic                      r_en_out,
  output logic                      w_en_in
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ACCESS  = 2'd1;
  localparam logic [1:0] S_RD_WAIT = 2'd2;

  localparam int CNT_W = (RD_WAIT < 2) ? 1 : $clog2(RD_WAIT + 1);

  localparam logic [ADDR_W-1:0] A_CTRL      = '0;
  localparam logic [ADDR_W-1:0] A_DATA_LAST = ADDR_W'(NUM_DATA);
  localparam logic [ADDR_W-1:0] A_RES       = ADDR_W'(NUM_DATA + 1);
  localparam logic [ADDR_W-1:0] A_STAT      = ADDR_W'(NUM_DATA + 2);
`ifdef CSR_ERR_CNT_EN
  localparam logic [ADDR_W-1:0] A_ERRCNT    = ADDR_W'(NUM_DATA + 3);
`endif
  // One bit wider than paddr so a power-of-two REG_NUMBER still compares correctly
  localparam logic [ADDR_W:0]   REG_LIMIT   = (ADDR_W + 1)'(REG_NUMBER);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              pwrite_q, pwrite_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ctrl_wr_q;

  logic is_ctrl, is_data, is_res, is_wr_reg, is_rd_reg, in_range, setup_err;

  assign is_ctrl   = (paddr == A_CTRL);
  assign is_data   = (paddr != A_CTRL) && (paddr <= A_DATA_LAST);
  assign is_res    = (paddr == A_RES);
  assign is_wr_reg = is_ctrl | is_data;
  assign in_range  = ({1'b0, paddr} < REG_LIMIT);

`ifdef CSR_ERR_CNT_EN
  logic [7:0] errcnt_q, errcnt_d;
  logic       errcnt_clr;

  assign is_rd_reg = is_res | (paddr == A_STAT) | (paddr == A_ERRCNT);
`else
  assign is_rd_reg = is_res | (paddr == A_STAT);
`endif

  assign setup_err = !in_range
                   | (is_wr_reg & !pwrite)
                   | (is_rd_reg & pwrite)
                   | (is_wr_reg & pwrite & full_in)
                   | (is_res & !pwrite & empty_out)
                   | (is_ctrl & pwrite & !OP_VALID_MASK[ctrl_op]);

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    pwrite_d = pwrite_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    pready   = 1'b0;
    pslverr  = 1'b0;
    prdata   = '0;
    en_ctrl  = 1'b0;
    en_data  = '0;
    r_en_out = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (psel && !penable) begin
          state_d  = S_ACCESS;
          addr_d   = paddr;
          pwrite_d = pwrite;
          err_d    = setup_err;
        end
      end
      S_ACCESS: begin
        state_d = S_IDLE;
        if (psel) begin
          if (err_q) begin
            pready  = 1'b1;
            pslverr = 1'b1;
          end else if (pwrite_q) begin
            pready = 1'b1;
            if (addr_q == A_CTRL) begin
              en_ctrl = 1'b1;
            end else begin
              for (int i = 0; i < NUM_DATA; i++) begin
                en_data[i] = (addr_q == ADDR_W'(i + 1));
              end
            end
          end else if (addr_q == A_RES) begin
            // Pop now so the FIFO head is valid by the time pready rises
            r_en_out = 1'b1;
            cnt_d    = CNT_W'(RD_WAIT);
            state_d  = S_RD_WAIT;
          end else begin
            pready = 1'b1;
`ifdef CSR_ERR_CNT_EN
            if (addr_q == A_ERRCNT) begin
              prdata = APB_BUS_SIZE'(errcnt_q);
            end else begin
              prdata = APB_BUS_SIZE'(fifo_out_status);
            end
`else
            prdata = APB_BUS_SIZE'(fifo_out_status);
`endif
          end
        end
      end
      S_RD_WAIT: begin
        if (!psel) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            pready  = 1'b1;
            prdata  = APB_BUS_SIZE'(final_result);
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // CTRL register has taken the new start bit one cycle after its strobe
  assign w_en_in = ctrl_wr_q & start_bit;

`ifdef CSR_ERR_CNT_EN
  assign errcnt_clr = (state_q == S_ACCESS) && psel && !err_q && !pwrite_q && (addr_q == A_ERRCNT);

  always_comb begin
    errcnt_d = errcnt_q;
    if (errcnt_clr) begin
      errcnt_d = pslverr ? 8'd1 : 8'd0;
    end else if (pslverr && (errcnt_q != 8'hFF)) begin
      errcnt_d = errcnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      errcnt_q <= '0;
    end else begin
      errcnt_q <= errcnt_d;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      pwrite_q  <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
      ctrl_wr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      pwrite_q  <= pwrite_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
      ctrl_wr_q <= en_ctrl;
    end
  end

endmodule

// File: tb/tb_csr_apb_ctrl_multi.sv
// tb/tb_csr_apb_ctrl_multi.sv - self-checking bench for csr_apb_ctrl_multi
module tb_csr_apb_ctrl_multi;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  paddr;
  logic        psel, penable, pwrite;
  logic [1:0]  ctrl_op;
  logic        start_bit, full_in, empty_out;
  logic [24:0] final_result, fifo_out_status;

  logic [31:0] prdata, prdata3;
  logic        pready, pslverr, en_ctrl, r_en_out, w_en_in;
  logic        pready3, pslverr3, en_ctrl3, r_en_out3, w_en_in3;
  logic [1:0]  en_data, en_data3;

  always #5 clk = ~clk;

  csr_apb_ctrl_multi #(.NUM_DATA(2), .RD_WAIT(1)) u_dut (
    .clk(clk), .rst(rst), .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
    .ctrl_op(ctrl_op), .start_bit(start_bit), .final_result(final_result),
    .fifo_out_status(fifo_out_status), .full_in(full_in), .empty_out(empty_out),
    .prdata(prdata), .pready(pready), .pslverr(pslverr), .en_ctrl(en_ctrl),
    .en_data(en_data), .r_en_out(r_en_out), .w_en_in(w_en_in)
  );

  csr_apb_ctrl_multi #(.NUM_DATA(2), .RD_WAIT(3)) u_dut3 (
    .clk(clk), .rst(rst), .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
    .ctrl_op(ctrl_op), .start_bit(start_bit), .final_result(final_result),
    .fifo_out_status(fifo_out_status), .full_in(full_in), .empty_out(empty_out),
    .prdata(prdata3), .pready(pready3), .pslverr(pslverr3), .en_ctrl(en_ctrl3),
    .en_data(en_data3), .r_en_out(r_en_out3), .w_en_in(w_en_in3)
  );

  typedef struct {
    logic [2:0]  addr;
    logic        wr;
    logic [1:0]  op;
    logic        start;
    logic        full;
    logic        empty;
    int          lat;
    logic        slv;
    logic [31:0] prdata;
    int          ectrl;
    logic [1:0]  emask;
    int          ecnt;
    int          ren;
    logic        wpost;
  } vec_t;

  typedef struct {
    int          lat;
    logic        slv;
    logic [31:0] prdata;
    int          ectrl;
    logic [1:0]  emask;
    int          ecnt;
    int          ren;
    logic        wpost;
    int          wtot;
    int          bad;
  } obs_t;

  int   checks = 0;
  int   errors = 0;
  vec_t tbl[14];
  vec_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic acc(inout obs_t o);
    o.ectrl += int'(en_ctrl);
    o.ecnt  += $countones(en_data);
    o.emask |= en_data;
    o.ren   += int'(r_en_out);
    o.wtot  += int'(w_en_in);
    if (!pready && pslverr) o.bad++;
  endtask

  task automatic run_xfer(input vec_t v, output obs_t o);
    bit done;
    int n;
    o.lat = 0; o.slv = 1'b0; o.prdata = '0; o.ectrl = 0; o.emask = '0;
    o.ecnt = 0; o.ren = 0; o.wpost = 1'b0; o.wtot = 0; o.bad = 0;
    @(posedge clk); #1;
    paddr = v.addr; pwrite = v.wr; ctrl_op = v.op; start_bit = v.start;
    full_in = v.full; empty_out = v.empty; psel = 1'b1; penable = 1'b0;
    @(negedge clk); acc(o);
    @(posedge clk); #1;
    penable = 1'b1;
    done = 1'b0;
    n = 0;
    while (!done && n < 16) begin
      @(negedge clk);
      n++;
      acc(o);
      if (pready) begin
        done = 1'b1;
        o.lat = n;
        o.slv = pslverr;
        o.prdata = prdata;
      end else begin
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    o.wpost = w_en_in;
    acc(o);
  endtask

  task automatic do_vec(input string nm, input vec_t v);
    obs_t o;
    vec_t e;
    exp_q.push_back(v);
    run_xfer(v, o);
    e = exp_q.pop_front();
    chk({nm, ".lat"},    32'(o.lat),   32'(e.lat));
    chk({nm, ".pslverr"}, 32'(o.slv),  32'(e.slv));
    chk({nm, ".prdata"}, o.prdata,     e.prdata);
    chk({nm, ".en_ctrl"}, 32'(o.ectrl), 32'(e.ectrl));
    chk({nm, ".en_data"}, 32'(o.emask), 32'(e.emask));
    chk({nm, ".en_data_cnt"}, 32'(o.ecnt), 32'(e.ecnt));
    chk({nm, ".r_en_out"}, 32'(o.ren), 32'(e.ren));
    chk({nm, ".w_en_post"}, 32'(o.wpost), 32'(e.wpost));
    chk({nm, ".w_en_total"}, 32'(o.wtot), 32'(e.wpost));
    chk({nm, ".slverr_no_ready"}, 32'(o.bad), 32'd0);
  endtask

  initial begin
    int n;
    int ren3;
    vec_t v;

    //          addr  wr    op     st    full  empty lat slv  prdata        ectrl emask  ecnt ren wpost
    tbl[0]  = '{3'd2, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1, 1'b0, 32'h0,        0, 2'b10, 1, 0, 1'b0};
    tbl[1]  = '{3'd1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1, 1'b0, 32'h0,        0, 2'b01, 1, 0, 1'b0};
    tbl[2]  = '{3'd0, 1'b1, 2'd1, 1'b1, 1'b0, 1'b0, 1, 1'b0, 32'h0,        1, 2'b00, 0, 0, 1'b1};
    tbl[3]  = '{3'd0, 1'b1, 2'd3, 1'b1, 1'b0, 1'b0, 1, 1'b1, 32'h0,        0, 2'b00, 0, 0, 1'b0};
    tbl[4]  = '{3'd0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 1, 1'b0, 32'h0,        1, 2'b00, 0, 0, 1'b0};
    tbl[5]  = '{3'd3, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 2, 1'b0, 32'h001ABCDE, 0, 2'b00, 0, 1, 1'b0};
    tbl[6]  = '{3'd3, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1, 1'b1, 32'h0,        0, 2'b00, 0, 0, 1'b0};
    tbl[7]  = '{3'd4, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1, 1'b0, 32'h005A5A5A, 0, 2'b00, 0, 0, 1'b0};
    tbl[8]  = '{3'd7, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1, 1'b1, 32'h0,        0, 2'b00, 0, 0, 1'b0};
    tbl[9]  = '{3'd0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 1, 1'b1, 32'h0,        0, 2'b00, 0, 0, 1'b0};
    tbl[10] = '{3'd3, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1, 1'b1, 32'h0,        0, 2'b00, 0, 0, 1'b0};
    tbl[11] = '{3'd1, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0, 1, 1'b1, 32'h0,        0, 2'b00, 0, 0, 1'b0};
    tbl[12] = '{3'd4, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1, 1'b0, 32'h005A5A5A, 0, 2'b00, 0, 0, 1'b0};
    tbl[13] = '{3'd6, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1, 1'b1, 32'h0,        0, 2'b00, 0, 0, 1'b0};

    rst = 1'b1;
    paddr = '0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; ctrl_op = '0;
    start_bit = 1'b0; full_in = 1'b0; empty_out = 1'b0;
    final_result = 25'h1ABCDE;
    fifo_out_status = 25'h05A5A5A;

    repeat (2) @(negedge clk);
    chk("rst.pready",   32'(pready),   32'd0);
    chk("rst.pslverr",  32'(pslverr),  32'd0);
    chk("rst.prdata",   prdata,        32'd0);
    chk("rst.en_ctrl",  32'(en_ctrl),  32'd0);
    chk("rst.en_data",  32'(en_data),  32'd0);
    chk("rst.r_en_out", 32'(r_en_out), 32'd0);
    chk("rst.w_en_in",  32'(w_en_in),  32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst.pready", 32'(pready), 32'd0);

    for (int i = 0; i < 14; i++) begin
      do_vec($sformatf("vec%0d", i), tbl[i]);
    end

    // RES read against the RD_WAIT=3 instance: ready on the fourth ACCESS cycle
    @(posedge clk); #1;
    paddr = 3'd3; pwrite = 1'b0; empty_out = 1'b0; psel = 1'b1; penable = 1'b0;
    @(posedge clk); #1;
    penable = 1'b1;
    n = 0;
    ren3 = 0;
    while (n < 10) begin
      @(negedge clk);
      n++;
      ren3 += int'(r_en_out3);
      if (pready3) break;
      @(posedge clk); #1;
    end
    chk("rdwait3.lat",     32'(n),        32'd4);
    chk("rdwait3.prdata",  prdata3,       32'h001ABCDE);
    chk("rdwait3.pslverr", 32'(pslverr3), 32'd0);
    chk("rdwait3.r_en",    32'(ren3),     32'd1);
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;

    // Back-to-back writes: SETUP of the second immediately after the first completes
    @(posedge clk); #1;
    paddr = 3'd1; pwrite = 1'b1; full_in = 1'b0; psel = 1'b1; penable = 1'b0;
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk);
    chk("b2b.first_ready", 32'(pready),  32'd1);
    chk("b2b.first_data",  32'(en_data), 32'b01);
    @(posedge clk); #1;
    paddr = 3'd2; penable = 1'b0;
    @(negedge clk);
    chk("b2b.setup_data",  32'(en_data), 32'b00);
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk);
    chk("b2b.second_ready", 32'(pready),  32'd1);
    chk("b2b.second_data",  32'(en_data), 32'b10);
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;

    // Reset while in RD_WAIT aborts with all outputs low
    @(posedge clk); #1;
    paddr = 3'd3; pwrite = 1'b0; empty_out = 1'b0; psel = 1'b1; penable = 1'b0;
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk);
    chk("rstwait.r_en", 32'(r_en_out), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("rstwait.outs", {19'd0, pready, pslverr, en_ctrl, en_data, r_en_out, w_en_in, pready3, pslverr3, r_en_out3, en_ctrl3, en_data3}, 32'd0);
    chk("rstwait.prdata", prdata, 32'd0);
    psel = 1'b0; penable = 1'b0;
    #1;
    rst = 1'b0;
    v = '{3'd4, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1, 1'b0, 32'h005A5A5A, 0, 2'b00, 0, 0, 1'b0};
    do_vec("rstwait.status", v);

`ifdef CSR_ERR_CNT_EN
    do_vec("errcnt.e0", tbl[3]);
    do_vec("errcnt.e1", tbl[6]);
    do_vec("errcnt.e2", tbl[8]);
    v = '{3'd5, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1, 1'b0, 32'h3, 0, 2'b00, 0, 0, 1'b0};
    do_vec("errcnt.read", v);
    v.prdata = 32'h0;
    do_vec("errcnt.reread", v);
`else
    v = '{3'd5, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1, 1'b1, 32'h0, 0, 2'b00, 0, 0, 1'b0};
    do_vec("noerrcnt.addr5", v);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
